// File: rtl/miner_pkg.sv
// Shared definitions for the nonce sweeper: FSM states, header size and
// byte-order helpers used between Bitcoin display order and core order.
package miner_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    START,
    WAIT,
    CHECK,
    FOUND,
    EXHAUSTED
  } state_t;

  localparam int          HDR_BYTES_DEF = 76;
  localparam logic [31:0] NONCE_MAX     = 32'hFFFF_FFFF;

  function automatic logic [31:0] bswap32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  function automatic logic [255:0] bswap256(input logic [255:0] v);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      r[8*i +: 8] = v[255-8*i -: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/hash_target_cmp.sv
// Difficulty check: byte-reverses the core digest into display order and
// reports a hit when its top zbits bits are all zero.
module hash_target_cmp
  import miner_pkg::*;
(
  input  logic [255:0] core_hash,
  input  logic [7:0]   zbits,
  output logic         hit
);

  logic [255:0] rev;
  int           zb_i;

  // zbits of 0 leaves the loop with nothing to veto, so it always hits.
  always_comb begin
    rev  = bswap256(core_hash);
    zb_i = int'(zbits);
    hit  = 1'b1;
    for (int i = 0; i < 256; i++) begin
      if (i < zb_i && rev[255-i]) begin
        hit = 1'b0;
      end
    end
  end

endmodule

// File: rtl/nonce_sweeper.sv
// Job controller for the double-SHA256 core: loads a header prefix, then
// restarts the core once per nonce until a digest meets the zero-bit target.
module nonce_sweeper
  import miner_pkg::*;
#(
  parameter int HDR_BYTES  = HDR_BYTES_DEF,
  parameter int WAIT_LIMIT = 1023
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_valid,
  input  logic [7:0]                cfg_byte,
  input  logic                      cfg_clear,
  input  logic [7:0]                zbits,
  input  logic [31:0]               nonce_start,
  input  logic                      go,
  input  logic                      abort,
  output logic                      busy,
  output logic                      hdr_ready,
  output logic                      found,
  output logic                      exhausted,
  output logic                      err,
  output logic [31:0]               nonce_out,
  output logic [255:0]              hash_out,
  output logic                      core_clr_n,
  output logic                      core_start,
  output logic [8*HDR_BYTES+31:0]   core_block,
  input  logic                      core_done,
  input  logic [255:0]              core_hash
);

  localparam int HDR_W  = 8 * HDR_BYTES;
  localparam int CNT_W  = $clog2(HDR_BYTES + 1);
  localparam int WCNT_W = $clog2(WAIT_LIMIT + 1);

  state_t              state;
  state_t              next_state;
  logic [HDR_W-1:0]    hdr;
  logic [CNT_W-1:0]    byte_cnt;
  logic [WCNT_W-1:0]   wait_cnt;
  logic [31:0]         nonce;
  logic [7:0]          zb;
  logic                abort_clr;
  logic                hit;
  logic                go_ok;
  logic                timeout;

  hash_target_cmp u_cmp (
    .core_hash (core_hash),
    .zbits     (zb),
    .hit       (hit)
  );

  assign hdr_ready  = (byte_cnt == CNT_W'(HDR_BYTES));
  assign core_block = {hdr, bswap32(nonce)};
  assign go_ok      = go && hdr_ready &&
                      (state == IDLE || state == FOUND || state == EXHAUSTED);
  assign timeout    = (wait_cnt == WCNT_W'(WAIT_LIMIT - 1));

  // Header bytes fill from the top of the block down; extra bytes are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr      <= '0;
      byte_cnt <= '0;
    end else if (!busy) begin
      if (cfg_clear) begin
        hdr      <= '0;
        byte_cnt <= '0;
      end else if (cfg_valid && !hdr_ready) begin
        for (int i = 0; i < HDR_BYTES; i++) begin
          if (byte_cnt == CNT_W'(i)) begin
            hdr[HDR_W-1-8*i -: 8] <= cfg_byte;
          end
        end
        byte_cnt <= byte_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    core_start = 1'b0;
    core_clr_n = !abort_clr;
    case (state)
      IDLE, FOUND, EXHAUSTED: begin
        if (go_ok) next_state = CLEAR;
      end
      CLEAR: begin
        busy       = 1'b1;
        core_clr_n = 1'b0;
        next_state = abort ? IDLE : START;
      end
      START: begin
        busy       = 1'b1;
        core_start = 1'b1;
        next_state = abort ? IDLE : WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (abort)          next_state = IDLE;
        else if (core_done) next_state = CHECK;
        else if (timeout)   next_state = IDLE;
      end
      CHECK: begin
        busy = 1'b1;
        if (abort)                   next_state = IDLE;
        else if (hit)                next_state = FOUND;
        else if (nonce == NONCE_MAX) next_state = EXHAUSTED;
        else                         next_state = CLEAR;
      end
      default: next_state = IDLE;
    endcase
  end

  // Sweep datapath; an abort freezes the nonce at the last attempted value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      found     <= 1'b0;
      exhausted <= 1'b0;
      err       <= 1'b0;
      nonce_out <= '0;
      hash_out  <= '0;
      nonce     <= '0;
      zb        <= '0;
      wait_cnt  <= '0;
      abort_clr <= 1'b0;
    end else begin
      abort_clr <= busy && abort;
      case (state)
        IDLE, FOUND, EXHAUSTED: begin
          if (go_ok) begin
            found     <= 1'b0;
            exhausted <= 1'b0;
            err       <= 1'b0;
            zb        <= zbits;
            nonce     <= nonce_start;
          end
        end
        START: wait_cnt <= '0;
        WAIT: begin
          if (!abort && !core_done) begin
            if (timeout) err      <= 1'b1;
            else         wait_cnt <= wait_cnt + WCNT_W'(1);
          end
        end
        CHECK: begin
          if (!abort) begin
            if (hit) begin
              nonce_out <= nonce;
              hash_out  <= core_hash;
              found     <= 1'b1;
            end else if (nonce == NONCE_MAX) begin
              exhausted <= 1'b1;
            end else begin
              nonce <= nonce + 32'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nonce_sweeper.sv
// Self-checking bench for nonce_sweeper with a behavioural stub core whose
// digest depends on the attempted nonce and a selectable mode.
module tb_nonce_sweeper;

  localparam int HB  = 76;
  localparam int WL  = 16;
  localparam int LAT = 3;

  localparam logic [607:0] GEN_HDR = {
    32'h01000000,
    256'h0,
    256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
    32'h29ab5f49,
    32'hffff001d
  };
  localparam logic [255:0] GEN_DISP =
    256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         cfg_valid = 1'b0;
  logic [7:0]   cfg_byte = 8'h00;
  logic         cfg_clear = 1'b0;
  logic [7:0]   zbits = 8'h00;
  logic [31:0]  nonce_start = 32'h0;
  logic         go = 1'b0;
  logic         abort = 1'b0;
  logic         busy, hdr_ready, found, exhausted, err;
  logic [31:0]  nonce_out;
  logic [255:0] hash_out;
  logic         core_clr_n, core_start;
  logic [639:0] core_block;
  logic         core_done;
  logic [255:0] core_hash;

  int           checks = 0;
  int           failures = 0;
  logic [607:0] m_hdr = '0;
  int           m_cnt = 0;
  logic [31:0]  sweep_start = 32'h0;
  int           start_count = 0;
  int           stub_mode = 3;
  bit           chk_on = 1'b0;

  nonce_sweeper #(.HDR_BYTES(HB), .WAIT_LIMIT(WL)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_valid   (cfg_valid),
    .cfg_byte    (cfg_byte),
    .cfg_clear   (cfg_clear),
    .zbits       (zbits),
    .nonce_start (nonce_start),
    .go          (go),
    .abort       (abort),
    .busy        (busy),
    .hdr_ready   (hdr_ready),
    .found       (found),
    .exhausted   (exhausted),
    .err         (err),
    .nonce_out   (nonce_out),
    .hash_out    (hash_out),
    .core_clr_n  (core_clr_n),
    .core_start  (core_start),
    .core_block  (core_block),
    .core_done   (core_done),
    .core_hash   (core_hash)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] rev256(input logic [255:0] v);
    logic [255:0] r;
    r = {<<8{v}};
    return r;
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    r = {<<8{v}};
    return r;
  endfunction

  // Digest in display order for a given nonce and stub personality.
  function automatic logic [255:0] disp_of(input logic [31:0] n, input int mode);
    case (mode)
      0:       return GEN_DISP;
      1:       return (n < 32'd5) ? {8'h01, {248{1'b1}}} : {8'h00, {248{1'b1}}};
      2:       return {8'hFF, 248'h0};
      default: return '0;
    endcase
  endfunction

  function automatic int clz(input logic [255:0] v);
    int c;
    c = 0;
    for (int i = 255; i >= 0; i--) begin
      if (v[i]) break;
      c++;
    end
    return c;
  endfunction

  task automatic check_output(input string name, input logic [639:0] act, input logic [639:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Stub core: digest appears LAT+1 cycles after start and holds until cleared.
  logic [2:0]  stub_cnt;
  bit          stub_act;
  logic [31:0] stub_nonce;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_done <= 1'b0;
      core_hash <= '0;
      stub_act  <= 1'b0;
      stub_cnt  <= '0;
      stub_nonce <= '0;
    end else if (!core_clr_n) begin
      core_done <= 1'b0;
      stub_act  <= 1'b0;
    end else if (core_start) begin
      stub_act   <= 1'b1;
      stub_cnt   <= 3'(LAT);
      stub_nonce <= rev32(core_block[31:0]);
      core_done  <= 1'b0;
    end else if (stub_act && stub_mode != 3) begin
      if (stub_cnt == 3'd0) begin
        core_done <= 1'b1;
        core_hash <= rev256(disp_of(stub_nonce, stub_mode));
        stub_act  <= 1'b0;
      end else begin
        stub_cnt <= stub_cnt - 3'd1;
      end
    end
  end

  // Per-cycle compare against the header model and the attempt sequence.
  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (chk_on && rst_n) begin
        check_output("hdr_ready", 640'(hdr_ready), 640'(m_cnt == HB));
        check_output("block_hdr", 640'(core_block[639:32]), 640'(m_hdr));
        if (core_start) begin
          check_output("attempt_nonce", 640'(rev32(core_block[31:0])),
                       640'(sweep_start + 32'(start_count)));
          check_output("busy_in_start", 640'(busy), 640'(1));
          start_count++;
        end
        if (found || exhausted || err) check_output("idle_when_flag", 640'(busy), 640'(0));
      end
    end
  end

  task automatic check_reset_values();
    check_output("rst_busy", 640'(busy), 640'(0));
    check_output("rst_hdr_ready", 640'(hdr_ready), 640'(0));
    check_output("rst_found", 640'(found), 640'(0));
    check_output("rst_exhausted", 640'(exhausted), 640'(0));
    check_output("rst_err", 640'(err), 640'(0));
    check_output("rst_nonce_out", 640'(nonce_out), 640'(0));
    check_output("rst_hash_out", 640'(hash_out), 640'(0));
    check_output("rst_core_clr_n", 640'(core_clr_n), 640'(1));
    check_output("rst_core_start", 640'(core_start), 640'(0));
    check_output("rst_core_block", core_block, 640'(0));
  endtask

  task automatic load_bytes(input int first, input int last);
    logic [607:0] hv;
    logic [607:0] tmp;
    for (int i = first; i <= last; i++) begin
      @(negedge clk);
      hv  = GEN_HDR;
      tmp = hv >> (8 * (HB - 1 - i));
      cfg_byte  = tmp[7:0];
      cfg_valid = 1'b1;
      if (m_cnt < HB) begin
        m_hdr = m_hdr | ({600'b0, tmp[7:0]} << (8 * (HB - 1 - m_cnt)));
        m_cnt++;
      end
    end
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [31:0] st, input logic [7:0] zb,
                                input int mode, input bit expect_accept);
    @(negedge clk);
    stub_mode   = mode;
    sweep_start = st;
    start_count = 0;
    nonce_start = st;
    zbits       = zb;
    go          = 1'b1;
    @(posedge clk);
    #3;
    if (expect_accept) begin
      check_output("go_clr_n_low", 640'(core_clr_n), 640'(0));
      check_output("go_busy", 640'(busy), 640'(1));
      check_output("go_flags_clear", 640'({found, exhausted, err}), 640'(0));
    end else begin
      check_output("go_ignored_busy", 640'(busy), 640'(0));
    end
    @(negedge clk);
    go = 1'b0;
    @(posedge clk);
    #3;
    check_output("go_core_start", 640'(core_start), 640'(expect_accept));
  endtask

  task automatic wait_end(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #3;
      if (found || exhausted || err) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("[TB] FAIL sweep_end: no result within %0d cycles", budget);
    end
    repeat (4) @(posedge clk);
    #3;
  endtask

  // Expected sweep outcome straight from the rules: walk nonces until a
  // digest clears the target or the top nonce is spent.
  task automatic check_sweep(input logic [31:0] st, input logic [7:0] zb, input int mode);
    logic [31:0] n;
    int          att;
    bit          f, x;
    n = st; att = 0; f = 1'b0; x = 1'b0;
    for (int k = 0; k < 64; k++) begin
      att++;
      if (clz(disp_of(n, mode)) >= int'(zb)) begin f = 1'b1; break; end
      if (n == 32'hFFFF_FFFF) begin x = 1'b1; break; end
      n++;
    end
    check_output("model_found", 640'(found), 640'(f));
    check_output("model_exhausted", 640'(exhausted), 640'(x));
    check_output("model_err", 640'(err), 640'(0));
    check_output("model_attempts", 640'(start_count), 640'(att));
    if (f) begin
      check_output("model_nonce_out", 640'(nonce_out), 640'(n));
      check_output("model_hash_out", 640'(hash_out), 640'(rev256(disp_of(n, mode))));
    end
  endtask

  initial begin
    int cyc;
    #1 rst_n = 1'b0;
    #1 check_reset_values();
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    chk_on = 1'b1;

    // cfg_clear beats a simultaneous byte strobe
    load_bytes(0, 2);
    @(negedge clk);
    cfg_clear = 1'b1; cfg_valid = 1'b1; cfg_byte = 8'h5A;
    m_hdr = '0; m_cnt = 0;
    @(negedge clk);
    cfg_clear = 1'b0; cfg_valid = 1'b0;

    // 75 bytes only: go must be ignored
    load_bytes(0, HB - 2);
    apply_stimulus(32'h0000_0010, 8'd8, 2, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    check_output("short_hdr_no_start", 640'(start_count), 640'(0));
    load_bytes(HB - 1, HB - 1);
    @(negedge clk);
    cfg_valid = 1'b1; cfg_byte = 8'hAA;
    @(negedge clk);
    cfg_valid = 1'b0;

    // genesis digest, one attempt
    apply_stimulus(32'h7C2B_AC1D, 8'd32, 0, 1'b1);
    wait_end(200);
    check_output("gen_found", 640'(found), 640'(1));
    check_output("gen_nonce", 640'(nonce_out), 640'(32'h7C2B_AC1D));
    check_output("gen_digest", 640'(rev256(hash_out)), 640'(GEN_DISP));
    check_output("gen_attempts", 640'(start_count), 640'(1));
    check_sweep(32'h7C2B_AC1D, 8'd32, 0);

    // hit on the sixth nonce
    apply_stimulus(32'h0, 8'd8, 1, 1'b1);
    wait_end(300);
    check_output("six_attempts", 640'(start_count), 640'(6));
    check_output("six_nonce", 640'(nonce_out), 640'(5));
    check_sweep(32'h0, 8'd8, 1);

    // exhaustion without wrap
    apply_stimulus(32'hFFFF_FFFE, 8'd8, 2, 1'b1);
    wait_end(200);
    check_output("exh_flag", 640'(exhausted), 640'(1));
    check_output("exh_found", 640'(found), 640'(0));
    check_output("exh_attempts", 640'(start_count), 640'(2));
    check_sweep(32'hFFFF_FFFE, 8'd8, 2);

    // target boundary: genesis digest has exactly 43 leading zeros
    apply_stimulus(32'hFFFF_FFFF, 8'd44, 0, 1'b1);
    wait_end(200);
    check_output("z44_exhausted", 640'(exhausted), 640'(1));
    check_sweep(32'hFFFF_FFFF, 8'd44, 0);
    apply_stimulus(32'hFFFF_FFFF, 8'd43, 0, 1'b1);
    wait_end(200);
    check_output("z43_found", 640'(found), 640'(1));
    check_sweep(32'hFFFF_FFFF, 8'd43, 0);

    // core never answers: timeout after WL cycles in WAIT
    apply_stimulus(32'h0000_0042, 8'd8, 3, 1'b1);
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #3;
      cyc++;
      if (err) break;
    end
    check_output("timeout_latency", 640'(cyc), 640'(WL + 1));
    check_output("timeout_err", 640'(err), 640'(1));
    check_output("timeout_busy", 640'(busy), 640'(0));
    check_output("timeout_nonce_held", 640'(rev32(core_block[31:0])), 640'(32'h0000_0042));
    apply_stimulus(32'h0000_1234, 8'd0, 2, 1'b1);
    check_output("go_clears_err", 640'(err), 640'(0));
    wait_end(200);
    check_sweep(32'h0000_1234, 8'd0, 2);

    // abort during WAIT
    apply_stimulus(32'hABCD_0001, 8'd8, 3, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #3;
    check_output("abort_busy", 640'(busy), 640'(0));
    check_output("abort_clr_n", 640'(core_clr_n), 640'(0));
    check_output("abort_flags", 640'({found, exhausted, err}), 640'(0));
    @(negedge clk);
    abort = 1'b0;
    @(posedge clk);
    #3;
    check_output("abort_clr_n_release", 640'(core_clr_n), 640'(1));
    check_output("abort_nonce_held", 640'(rev32(core_block[31:0])), 640'(32'hABCD_0001));

    // reset mid-WAIT
    apply_stimulus(32'h0000_0777, 8'd8, 3, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values();
    m_hdr = '0;
    m_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #3;
    check_output("post_reset_hdr_ready", 640'(hdr_ready), 640'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nonce_sweeper.md
# nonce_sweeper

Job controller that drives the double-SHA256 hash core from the initiator side. It accepts a 76-byte block-header prefix over a byte-serial load port and sweeps the 32-bit nonce from a given start value. For each nonce it restarts the core, waits for its digest and checks the digest against a leading-zero-bits target. It reports the first winning nonce and digest, or reports exhaustion, timeout or abort.

## Interface
- HDR_BYTES, 76, header prefix length in bytes (nonce excluded)
- WAIT_LIMIT, 1023, maximum cycles in WAIT before timeout
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_valid  in  1  header byte strobe
- cfg_byte  in  8  header byte; byte 0 first, lands in core_block[639:632]
- cfg_clear  in  1  discard loaded header, byte count to 0
- zbits  in  8  required leading zero bits, sampled on accepted go
- nonce_start  in  32  first nonce, sampled on accepted go
- go  in  1  start sweep
- abort  in  1  stop sweep
- busy  out  1  sweep in progress
- hdr_ready  out  1  all HDR_BYTES loaded
- found  out  1  winning nonce latched
- exhausted  out  1  nonce 0xFFFFFFFF tried without success
- err  out  1  core timeout
- nonce_out  out  32  winning nonce
- hash_out  out  256  winning digest, core order
- core_clr_n  out  1  synchronous restart strobe to core, active-low
- core_start  out  1  one-cycle start pulse to core
- core_block  out  640  {header prefix, byte-reversed nonce}
- core_done  in  1  core digest valid (level)
- core_hash  in  256  core digest

## Operation
- States: IDLE, CLEAR, START, WAIT, CHECK, FOUND, EXHAUSTED.
- Load: accepted only when not busy. Each cfg_valid cycle stores one byte and increments the byte count. Bytes past HDR_BYTES are ignored. hdr_ready = (count == HDR_BYTES). cfg_clear wins over a simultaneous cfg_valid.
- core_block[31:0] = {nonce[7:0], nonce[15:8], nonce[23:16], nonce[31:24]}.
- go is accepted only in IDLE/FOUND/EXHAUSTED with hdr_ready=1; otherwise it is ignored.
  - Accepted go clears found/exhausted/err, latches zbits and nonce_start, and moves to CLEAR.
- CLEAR: core_clr_n=0 for 1 cycle → START.
- START: core_start=1 for 1 cycle; wait counter reset → WAIT.
- WAIT: on first cycle with core_done=1 → CHECK.
  - Wait counter reaching WAIT_LIMIT sets err and returns to IDLE; nonce is not advanced.
- CHECK: rev = byte-reversal of core_hash (Bitcoin display order).
  - Success when the top zbits bits of rev are zero; zbits=0 always succeeds.
  - Success: latch nonce_out and hash_out, found=1 → FOUND.
  - Else if nonce==0xFFFFFFFF: exhausted=1 → EXHAUSTED, no wrap to 0.
  - Else nonce+1 → CLEAR.
- abort in CLEAR/START/WAIT/CHECK → IDLE next cycle, with core_clr_n=0 in that cycle. found/exhausted remain 0 and the nonce register holds the last attempted value. abort wins over a same-cycle CHECK result.
- busy=1 in CLEAR/START/WAIT/CHECK.

## Timing
- Reset values: busy=0, hdr_ready=0, found=0, exhausted=0, err=0, nonce_out=0, hash_out=0, core_clr_n=1, core_start=0, core_block=0, state IDLE, byte count 0.
- Accepted go at edge N: core_clr_n low in cycle N+1, core_start high in N+2.
- Per-attempt overhead: 3 cycles (CLEAR, START, CHECK) plus the core's latency.
- found/exhausted/err assert the cycle after CHECK or timeout and hold until the next accepted go or reset.
- rst_n low mid-sweep: all state returns to reset values immediately; the header is lost.

## Structure
- Shared package miner_pkg holds:
  - state enum
  - HDR_BYTES default
  - NONCE_MAX = 32'hFFFFFFFF
  - the byte-reverse function for 32 and 256 bits
- One sub-module, hash_target_cmp: combinational byte reversal of core_hash plus the zbits-prefix zero check. It has a single output, hit.

## Test plan
- Genesis header prefix (76 bytes) loaded, zbits=32, nonce_start=0x7C2BAC1D, with the real core → found=1 after one attempt; nonce_out=0x7C2BAC1D; rev(hash_out)=000000000019d6689c…8ce26f.
- Stub core returning rev top byte 0x01 for nonce 0..4 and 0x00 for nonce 5, zbits=8, nonce_start=0 → exactly 6 core_start pulses, nonce_out=5.
- nonce_start=0xFFFFFFFE, stub never hits, zbits=8 → 2 attempts, exhausted=1, found=0, no third core_start.
- Stub never raises core_done, WAIT_LIMIT=16 → err=1 exactly 16 cycles after entering WAIT; busy=0; next go clears err.
- go with only 75 bytes loaded → ignored, busy stays 0. abort raised during WAIT → IDLE next cycle, core_clr_n low in that cycle, found=0.
- Reset asserted mid-WAIT → all outputs at reset values in the same cycle; hdr_ready=0 after release.
